// File: rtl/instr_encoder.sv
// Packs decoded RV32I fields plus a full 32-bit immediate into an instruction word.
// Each encodable word is queued with its instruction-memory write address.
module instr_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  input  logic        addr_clr,
  input  logic        err_clr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err_sticky,
  output logic [7:0]  err_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    FMT_I = 3'd0,
    FMT_S = 3'd1,
    FMT_B = 3'd2,
    FMT_U = 3'd3,
    FMT_J = 3'd4,
    FMT_R = 3'd5
  } fmt_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW:0]     count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]     addr_q, addr_d;
  logic            err_sticky_q, err_sticky_d;
  logic [7:0]      err_count_q, err_count_d;

  fmt_e            fmt;
  logic [31:0]     packed_instr;
  logic            legal;
  logic            accept;
  logic            push;
  logic            pop;

  assign fmt = fmt_e'(in_fmt);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    packed_instr = '0;
    legal        = 1'b0;
    case (fmt)
      FMT_I: begin
        packed_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        legal        = (&in_imm[31:11]) | ~(|in_imm[31:11]);
      end
      FMT_S: begin
        packed_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        legal        = (&in_imm[31:11]) | ~(|in_imm[31:11]);
      end
      FMT_B: begin
        packed_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                        in_imm[4:1], in_imm[11], in_opcode};
        legal        = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
      end
      FMT_U: begin
        packed_instr = {in_imm[31:12], in_rd, in_opcode};
        legal        = ~(|in_imm[11:0]);
      end
      FMT_J: begin
        packed_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        legal        = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];
      end
      FMT_R: begin
        packed_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        legal        = 1'b1;
      end
      default: begin
        packed_instr = '0;
        legal        = 1'b0;
      end
    endcase
  end

  // DEPTH is a power of two, so the count MSB alone marks "full".
  assign in_ready  = ~count_q[AW];
  assign out_valid = |count_q;
  assign accept    = in_valid & in_ready;
  assign push      = accept & legal;
  assign pop       = out_valid & out_ready;

  always_comb begin
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    addr_d       = addr_q;
    err_sticky_d = err_sticky_q;
    err_count_d  = err_count_q;

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      addr_d   = addr_q + 32'd4;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (addr_clr) begin
      addr_d = BASE_ADDR;
    end

    if (accept && !legal) begin
      err_sticky_d = 1'b1;
      if (err_count_q != 8'hFF) begin
        err_count_d = err_count_q + 8'd1;
      end
    end
    if (err_clr) begin
      err_sticky_d = 1'b0;
      err_count_d  = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      addr_q       <= BASE_ADDR;
      err_sticky_q <= 1'b0;
      err_count_q  <= 8'd0;
    end else begin
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      addr_q       <= addr_d;
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; count_q gates every read, so stale words never escape.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{instr: packed_instr, addr: addr_q};
    end
  end

  assign out_instr  = out_valid ? mem_q[rd_ptr_q].instr : 32'd0;
  assign out_addr   = out_valid ? mem_q[rd_ptr_q].addr  : 32'd0;
  assign err_sticky = err_sticky_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a driver pushes model predictions into a queue,
// a negedge monitor pops and compares every word the DUT hands over.
module tb_instr_encoder;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        addr_clr, err_clr;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_addr;
  logic        err_sticky;
  logic [7:0]  err_count;

  instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .addr_clr(addr_clr), .err_clr(err_clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .err_sticky(err_sticky), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } req_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_addr;
  int          m_err;
  bit          m_sticky;
  int          checks = 0;
  int          errors = 0;
  bit          rand_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: legality from the signed range of the immediate, packing from the field layout.
  function automatic void ref_encode(input req_t r, output logic [31:0] w, output bit ok);
    int s;
    s = $signed(r.imm);
    w = 32'd0;
    ok = 1'b0;
    case (r.fmt)
      3'd0: begin
        ok = (s >= -2048) && (s <= 2047);
        w = {r.imm[11:0], r.rs1, r.f3, r.rd, r.op};
      end
      3'd1: begin
        ok = (s >= -2048) && (s <= 2047);
        w = {r.imm[11:5], r.rs2, r.rs1, r.f3, r.imm[4:0], r.op};
      end
      3'd2: begin
        ok = (s >= -4096) && (s <= 4095) && ((r.imm % 32'd2) == 0);
        w = {r.imm[12], r.imm[10:5], r.rs2, r.rs1, r.f3, r.imm[4:1], r.imm[11], r.op};
      end
      3'd3: begin
        ok = (r.imm % 32'd4096) == 0;
        w = {r.imm[31:12], r.rd, r.op};
      end
      3'd4: begin
        ok = (s >= -1048576) && (s <= 1048575) && ((r.imm % 32'd2) == 0);
        w = {r.imm[20], r.imm[10:1], r.imm[11], r.imm[19:12], r.rd, r.op};
      end
      3'd5: begin
        ok = 1'b1;
        w = {r.f7, r.rs2, r.rs1, r.f3, r.rd, r.op};
      end
      default: begin
        ok = 1'b0;
        w = 32'd0;
      end
    endcase
  endfunction

  function automatic void model_accept(input req_t r, input bit clr);
    logic [31:0] w;
    bit ok;
    ref_encode(r, w, ok);
    if (ok) begin
      sb_q.push_back('{instr: w, addr: m_addr});
      m_addr = m_addr + 32'd4;
    end else begin
      m_sticky = 1'b1;
      if (m_err < 255) m_err++;
    end
    if (clr) m_addr = BASE;
  endfunction

  function automatic req_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [31:0] imm);
    req_t r;
    r.fmt = fmt; r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.f3 = f3;
    r.f7 = 7'h00; r.imm = imm;
    return r;
  endfunction

  function automatic req_t rand_req(input bit force_r);
    req_t r;
    r.fmt = force_r ? 3'd5 : 3'($urandom_range(0, 7));
    r.op  = 7'($urandom);
    r.rd  = 5'($urandom);
    r.rs1 = 5'($urandom);
    r.rs2 = 5'($urandom);
    r.f3  = 3'($urandom);
    r.f7  = 7'($urandom);
    case ($urandom_range(0, 3))
      0: r.imm = $urandom;
      1: r.imm = 32'(int'($urandom_range(0, 8191)) - 4096);
      2: r.imm = $urandom & 32'hFFFF_F000;
      default: r.imm = 32'(int'($urandom_range(0, 2097151)) - 1048576);
    endcase
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic drive(input req_t r, input bit clr);
    int waited = 0;
    in_valid = 1'b1; in_fmt = r.fmt; in_opcode = r.op; in_rd = r.rd; in_rs1 = r.rs1;
    in_rs2 = r.rs2; in_funct3 = r.f3; in_funct7 = r.f7; in_imm = r.imm; addr_clr = clr;
    while (!in_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready stuck low for %0d cycles", waited);
    end else begin
      model_accept(r, clr);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    addr_clr = 1'b0;
  endtask

  task automatic pulse_addr_clr();
    addr_clr = 1'b1;
    @(posedge clk); #1;
    addr_clr = 1'b0;
    m_addr = BASE;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    m_err = 0;
    m_sticky = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (sb_q.size() != 0 || out_valid) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, out_valid=%0b", sb_q.size(), out_valid);
    end
  endtask

  // Monitor: compares every handed-over word against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_out: got instr 0x%08h addr 0x%08h with empty scoreboard",
                     out_instr, out_addr);
          end else begin
            e = sb_q.pop_front();
            check("sb_instr", out_instr, e.instr);
            check("sb_addr", out_addr, e.addr);
          end
        end else if (!out_valid) begin
          check("empty_instr_zero", out_instr, 32'd0);
          check("empty_addr_zero", out_addr, 32'd0);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0;
    in_rs2 = '0; in_funct3 = '0; in_funct7 = '0; in_imm = '0; addr_clr = 1'b0;
    err_clr = 1'b0; out_ready = 1'b0; rand_done = 1'b0;
    m_addr = BASE; m_err = 0; m_sticky = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_addr", out_addr, 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_err_sticky", 32'(err_sticky), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed encodings
    out_ready = 1'b1;
    drive(mk(3'd0, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 32'hFFFF_FFFF), 1'b0);
    check("i_instr", out_instr, 32'hFFF1_0093);
    check("i_addr", out_addr, BASE);
    drive(mk(3'd1, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 32'd8), 1'b0);
    check("s_instr", out_instr, 32'h0051_2423);
    check("s_addr", out_addr, BASE + 32'd4);
    drive(mk(3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFC), 1'b0);
    check("b_instr", out_instr, 32'hFE00_0EE3);
    check("b_addr", out_addr, BASE + 32'd8);

    // Rejections
    drive(mk(3'd0, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 32'h0000_0800), 1'b0);
    drive(mk(3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd7), 1'b0);
    @(posedge clk); #1;
    check("rej_out_valid", 32'(out_valid), 32'd0);
    check("rej_err_count", 32'(err_count), 32'd2);
    check("rej_err_sticky", 32'(err_sticky), 32'd1);
    drive(mk(3'd5, 7'h33, 5'd4, 5'd5, 5'd6, 3'd0, 32'd0), 1'b0);
    check("rej_next_addr", out_addr, BASE + 32'd12);
    pulse_err_clr();
    check("errclr_count", 32'(err_count), 32'd0);
    check("errclr_sticky", 32'(err_sticky), 32'd0);
    wait_drain();

    // Fill to DEPTH with the sink stalled, fifth request held until one pop
    pulse_addr_clr();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive(rand_req(1'b1), 1'b0);
    check("full_in_ready", 32'(in_ready), 32'd0);
    fork
      drive(rand_req(1'b1), 1'b0);
      begin
        repeat (3) begin
          @(posedge clk); #1;
          check("full_held", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // addr_clr coinciding with the third accept
    pulse_addr_clr();
    drive(rand_req(1'b1), 1'b0);
    drive(rand_req(1'b1), 1'b0);
    drive(rand_req(1'b1), 1'b1);
    check("clr_third_addr", out_addr, BASE + 32'd8);
    drive(mk(3'd3, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 32'h1234_5000), 1'b0);
    check("u_instr", out_instr, 32'h1234_51B7);
    check("u_addr", out_addr, BASE);
    wait_drain();

    // Reset with entries queued
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive(rand_req(1'b1), 1'b0);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_instr", out_instr, 32'd0);
    sb_q.delete();
    m_addr = BASE; m_err = 0; m_sticky = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive(rand_req(1'b1), 1'b0);
    check("post_rst_addr", out_addr, BASE);
    wait_drain();

    // Randomized traffic with a randomly stalling sink
    fork
      begin
        for (int i = 0; i < 400; i++) drive(rand_req(1'b0), 1'b0);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
    check("final_err_count", 32'(err_count), 32'(m_err));
    check("final_err_sticky", 32'(err_sticky), 32'(m_sticky));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
